clk_edge_monitor: RTL and testbench

Receive-side companion to the team's clock divider. It samples a divided or slow clock signal (clk_src) as asynchronous data in the fast clk_in domain and produces single-cycle rise and fall enables for downstream logic such as VGA pixel-tick consumers. It also measures the clk_src period in clk_in cycles, reports lock when the period is stable, and flags clock loss after a timeout.

---
 rtl/clk_edge_monitor_pkg.sv | 37 +++
 rtl/clk_edge_monitor_sync_edge_detect.sv | 53 +++++
 rtl/clk_edge_monitor.sv | 141 ++++++++++++++
 tb/tb_clk_edge_monitor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/clk_edge_monitor_pkg.sv
// Shared definitions for the clk_src edge monitor: FSM encoding and the
// elaboration-time parameter legality checks.
package clk_edge_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_LOST    = 2'd3
   } mon_state_e;

   localparam int MIN_SYNC_STAGES = 2;
   localparam int MIN_TIMEOUT     = 2;
   localparam int MIN_LOCK_COUNT  = 1;
   localparam int MAX_CNT_W       = 62;

   function automatic bit sync_stages_ok(input int sync_stages);
      return sync_stages >= MIN_SYNC_STAGES;
   endfunction

   // TIMEOUT-1 must be reachable by the saturating counter.
   function automatic bit monitor_params_ok(input int sync_stages,
                                            input int cnt_w,
                                            input int timeout,
                                            input int lock_count);
      longint cnt_span;
      if (cnt_w < 1 || cnt_w > MAX_CNT_W) begin
         return 1'b0;
      end
      cnt_span = longint'(1) << cnt_w;
      return sync_stages_ok(sync_stages) &&
             (timeout >= MIN_TIMEOUT) &&
             (longint'(timeout) < cnt_span) &&
             (lock_count >= MIN_LOCK_COUNT);
   endfunction

endpackage

// File: rtl/clk_edge_monitor_sync_edge_detect.sv
// Brings clk_src into the clk_in domain and turns its level changes into
// registered one-cycle rise/fall pulses.
module sync_edge_detect
   import clk_edge_monitor_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic reset_n,
   input  logic clk_src,
   output logic rise_pulse,
   output logic fall_pulse
);

   generate
      if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
         $error("sync_edge_detect: SYNC_STAGES must be at least 2");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   synced;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], clk_src};
      synced = sync_q[SYNC_STAGES-1];
      hist_d = synced;
      rise_d = synced & ~hist_q;
      fall_d = ~synced & hist_q;
   end

   // History resets low, so a clk_src already high at reset release is seen as a rise.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule

// File: rtl/clk_edge_monitor.sv
// Monitors a slow clock sampled in the clk_in domain: edge enables, rise-to-rise
// period measurement, lock detection and loss-of-clock timeout.
module clk_edge_monitor
   import clk_edge_monitor_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT     = 1024,
   parameter int LOCK_COUNT  = 4
) (
   input  logic             clk_in,
   input  logic             reset_n,
   input  logic             clk_src,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             clk_lost
);

   localparam int                 MATCH_W      = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [MATCH_W-1:0] LOCK_TARGET  = MATCH_W'(LOCK_COUNT);

   generate
      if (!monitor_params_ok(SYNC_STAGES, CNT_W, TIMEOUT, LOCK_COUNT)) begin : g_bad_params
         $error("clk_edge_monitor: illegal SYNC_STAGES/CNT_W/TIMEOUT/LOCK_COUNT combination");
      end
   endgenerate

   mon_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic               rise_evt;
   logic               timeout_evt;
   logic               same_period;
   logic               period_strobe;

   function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Clamped at the lock target so a run of equal periods can never wrap the count.
   function automatic logic [MATCH_W-1:0] match_sat_inc(input logic [MATCH_W-1:0] m);
      return (m >= LOCK_TARGET) ? LOCK_TARGET : m + MATCH_W'(1);
   endfunction

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge_detect (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
      .clk_src    (clk_src),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   assign rise_evt = rise_pulse;

   always_comb begin
      state_d       = state_q;
      cnt_d         = rise_evt ? CNT_W'(1) : cnt_sat_inc(cnt_q);
      last_d        = last_q;
      period_d      = period_q;
      match_d       = match_q;
      period_strobe = 1'b0;
      timeout_evt   = (cnt_q == TIMEOUT_LAST) && !rise_evt;
      same_period   = (cnt_q == last_q);

      case (state_q)
         ST_IDLE: begin
            if (rise_evt) begin
               state_d = ST_MEASURE;
            end else if (timeout_evt) begin
               state_d = ST_LOST;
            end
         end
         ST_MEASURE: begin
            if (rise_evt) begin
               period_strobe = 1'b1;
               period_d      = cnt_q;
               last_d        = cnt_q;
               match_d       = same_period ? match_sat_inc(match_q) : MATCH_W'(1);
               if (match_d == LOCK_TARGET) begin
                  state_d = ST_LOCKED;
               end
            end else if (timeout_evt) begin
               state_d = ST_LOST;
            end
         end
         ST_LOCKED: begin
            if (rise_evt) begin
               period_strobe = 1'b1;
               period_d      = cnt_q;
               if (!same_period) begin
                  state_d = ST_MEASURE;
                  match_d = MATCH_W'(1);
                  last_d  = cnt_q;
               end
            end else if (timeout_evt) begin
               state_d = ST_LOST;
            end
         end
         ST_LOST: begin
            // The interval spanning the outage is meaningless, so it is not reported.
            if (rise_evt) begin
               state_d = ST_MEASURE;
               match_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         last_q   <= '0;
         period_q <= '0;
         match_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         period_q <= period_d;
         match_q  <= match_d;
      end
   end

   assign period       = period_q;
   assign period_valid = period_strobe;
   assign locked       = (state_q == ST_LOCKED);
   assign clk_lost     = (state_q == ST_LOST);

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Directed bench for clk_edge_monitor with default parameters: edge timing table,
// lock, stretched period, loss/resume, reset with clk_src high, async reset.
module tb_clk_edge_monitor;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 1024;

   logic             clk_in = 1'b0;
   logic             reset_n;
   logic             clk_src;
   logic             rise_pulse;
   logic             fall_pulse;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             locked;
   logic             clk_lost;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic src;
      logic rise;
      logic fall;
      logic pv;
   } edge_vec_t;

   edge_vec_t vecs [9];

   clk_edge_monitor #(
      .SYNC_STAGES (2),
      .CNT_W       (CNT_W),
      .TIMEOUT     (TIMEOUT),
      .LOCK_COUNT  (4)
   ) dut (
      .clk_in       (clk_in),
      .reset_n      (reset_n),
      .clk_src      (clk_src),
      .rise_pulse   (rise_pulse),
      .fall_pulse   (fall_pulse),
      .period       (period),
      .period_valid (period_valid),
      .locked       (locked),
      .clk_lost     (clk_lost)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_outs(input string name, input int s,
                             input logic er, input logic ef, input logic epv,
                             input logic elk, input logic elost,
                             input logic [CNT_W-1:0] eper);
      logic [4:0] act;
      logic [4:0] exp;
      act = {rise_pulse, fall_pulse, period_valid, locked, clk_lost};
      exp = {er, ef, epv, elk, elost};
      n_checks++;
      if (act !== exp || period !== eper) begin
         n_errors++;
         $display("FAIL %s step %0d: got rise/fall/pv/locked/lost=%b period=%0d, want %b period=%0d",
                  name, s, act, period, exp, eper);
      end
   endtask

   task automatic step(input logic src);
      clk_src = src;
      @(negedge clk_in);
   endtask

   task automatic do_reset(input logic src);
      reset_n = 1'b0;
      clk_src = src;
      repeat (3) @(negedge clk_in);
      check_outs("reset_state", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      reset_n = 1'b1;
   endtask

   // Square wave high 4 / low 4 starting at step 1; rise n seen at step 8n-5.
   task automatic run_lock(input int last, input string tag);
      logic er, ef, epv, elk;
      logic [CNT_W-1:0] eper;
      for (int s = 1; s <= last; s++) begin
         step(((s - 1) % 8) < 4);
         er   = (s >= 3) && ((s - 3) % 8 == 0);
         ef   = (s >= 7) && ((s - 7) % 8 == 0);
         epv  = er && (s >= 11);
         elk  = (s >= 36);
         eper = (s >= 12) ? CNT_W'(8) : CNT_W'(0);
         check_outs(tag, s, er, ef, epv, elk, 1'b0, eper);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic src, er, ef, epv, elk, elost;
      logic [CNT_W-1:0] eper;

      reset_n = 1'b0;
      clk_src = 1'b0;

      // single rise and fall: pulse on the third edge counting the sampling edge
      vecs[0] = '{src: 1'b0, rise: 1'b0, fall: 1'b0, pv: 1'b0};
      vecs[1] = '{src: 1'b1, rise: 1'b0, fall: 1'b0, pv: 1'b0};
      vecs[2] = '{src: 1'b1, rise: 1'b0, fall: 1'b0, pv: 1'b0};
      vecs[3] = '{src: 1'b1, rise: 1'b1, fall: 1'b0, pv: 1'b0};
      vecs[4] = '{src: 1'b1, rise: 1'b0, fall: 1'b0, pv: 1'b0};
      vecs[5] = '{src: 1'b0, rise: 1'b0, fall: 1'b0, pv: 1'b0};
      vecs[6] = '{src: 1'b0, rise: 1'b0, fall: 1'b0, pv: 1'b0};
      vecs[7] = '{src: 1'b0, rise: 1'b0, fall: 1'b1, pv: 1'b0};
      vecs[8] = '{src: 1'b0, rise: 1'b0, fall: 1'b0, pv: 1'b0};

      do_reset(1'b0);
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].src);
         check_outs($sformatf("edge_vec%0d", i), i + 1, vecs[i].rise, vecs[i].fall,
                    vecs[i].pv, 1'b0, 1'b0, '0);
      end

      // lock on period 8
      do_reset(1'b0);
      run_lock(64, "lock");

      // one period stretched to 10, then relock after four periods of 8
      for (int s = 65; s <= 116; s++) begin
         src = (s <= 70) ? 1'b1 : (s <= 74) ? 1'b0 : (((s - 75) % 8) < 4);
         step(src);
         er   = (s == 67) || ((s >= 77) && ((s - 77) % 8 == 0));
         ef   = (s == 73) || ((s >= 81) && ((s - 81) % 8 == 0));
         epv  = er;
         elk  = (s <= 77) || (s >= 110);
         eper = ((s >= 78) && (s <= 85)) ? CNT_W'(10) : CNT_W'(8);
         check_outs("stretch", s, er, ef, epv, elk, 1'b0, eper);
      end

      // clk_src held high: last rise at 117, loss declared TIMEOUT cycles later
      for (int s = 117; s <= 1145; s++) begin
         step(1'b1);
         er    = (s == 117);
         elost = (s >= 117 + TIMEOUT);
         elk   = !elost;
         check_outs("timeout", s, er, 1'b0, er, elk, elost, CNT_W'(8));
      end

      // resume: first rise has no period, second reports 8
      for (int s = 1146; s <= 1190; s++) begin
         src = (s < 1150) ? 1'b0 : (((s - 1150) % 8) < 4);
         step(src);
         er    = (s >= 1152) && ((s - 1152) % 8 == 0);
         ef    = (s == 1148) || ((s >= 1156) && ((s - 1156) % 8 == 0));
         epv   = er && (s >= 1160);
         elost = (s <= 1152);
         elk   = (s >= 1185);
         check_outs("resume", s, er, ef, epv, elk, elost, CNT_W'(8));
      end

      // clk_src high through reset release: rise counts, state measures
      do_reset(1'b1);
      for (int s = 1; s <= 18; s++) begin
         src = (s <= 8) ? 1'b1 : (s <= 12) ? 1'b0 : 1'b1;
         step(src);
         er   = (s == 3) || (s == 15);
         ef   = (s == 11);
         epv  = (s == 15);
         eper = (s >= 16) ? CNT_W'(12) : CNT_W'(0);
         check_outs("reset_high", s, er, ef, epv, 1'b0, 1'b0, eper);
      end

      // asynchronous reset while locked, then relock
      do_reset(1'b0);
      run_lock(40, "pre_reset_lock");
      #2;
      reset_n = 1'b0;
      clk_src = 1'b0;
      #1;
      check_outs("async_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk_in);
      reset_n = 1'b1;
      run_lock(40, "relock");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
